intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-triggered interrupt controller with an MMIO register
// block (PEND, EN, CUR, ACK) and a one-at-a-time pulse/acknowledge FSM.
//
// Ports:
//   CLK         clock; all state changes on its rising edge
//   RST         asynchronous active-high reset
//   SRC_IN      interrupt request levels, synchronous to CLK
//   IOBUS_ADDR  CPU MMIO address
//   IOBUS_OUT   CPU write data
//   IOBUS_WR    CPU write strobe (one cycle)
//   RD_DATA     read data for the IOBUS_IN mux (0 when not hit)
//   RD_HIT      IOBUS_ADDR lies in BASE_AD..BASE_AD+12
//   INTR        interrupt request pulse to the CPU
//
// Register map (offsets from BASE_AD):
//   +0  PEND  read, write-1-to-clear
//   +4  EN    read/write
//   +8  CUR   read only: bit 31 busy, bits 2:0 current id
//   +12 ACK   write only: IOBUS_OUT[2:0] = id being acknowledged
module intr_ctrl #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_AD   = 32'h11000080,
    parameter int          PULSE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] SRC_IN,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      RD_DATA,
    output logic             RD_HIT,
    output logic             INTR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_ACK
    } state_t;

    state_t           r_state;
    logic [2:0]       r_id;
    logic [3:0]       r_cnt;
    logic             r_intr;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_en;
    logic [N_SRC-1:0] r_src_q;
    logic             r_armed;

    logic [31:0]      w_off;
    logic             w_hit;
    logic             w_sel_pend;
    logic             w_sel_en;
    logic             w_sel_cur;
    logic             w_sel_ack;
    logic             w_busy;
    logic             w_ack_ok;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_ack_mask;
    logic [N_SRC-1:0] w_clr;
    logic [2:0]       w_next_id;
    logic [31:0]      w_rd;
    logic             w_unused_bits;

    // Offset arithmetic keeps the hit test safe against address wrap.
    assign w_off      = IOBUS_ADDR - BASE_AD;
    assign w_hit      = (w_off <= 32'd12);
    assign w_sel_pend = (w_off == 32'd0);
    assign w_sel_en   = (w_off == 32'd4);
    assign w_sel_cur  = (w_off == 32'd8);
    assign w_sel_ack  = (w_off == 32'd12);

    assign w_busy   = (r_state != ST_IDLE);
    assign w_req    = r_pend & r_en;
    assign w_ack_ok = IOBUS_WR && w_sel_ack
                   && (r_state == ST_WAIT_ACK)
                   && (IOBUS_OUT[2:0] == r_id);

    // The first edge after reset only reloads src_q, so a level held
    // high across reset release is never mistaken for a new request.
    assign w_rise = r_armed ? (SRC_IN & ~r_src_q) : '0;

    assign w_unused_bits = ^IOBUS_OUT[31:N_SRC];

    // Lowest index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_next_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_next_id = 3'(i);
            end
        end
    end

    always_comb begin
        w_ack_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_id == 3'(i)) begin
                w_ack_mask[i] = w_ack_ok;
            end
        end
    end

    assign w_clr = ((IOBUS_WR && w_sel_pend) ? IOBUS_OUT[N_SRC-1:0] : '0)
                 | w_ack_mask;

    always_comb begin
        w_rd = '0;
        unique case (1'b1)
            w_sel_pend: w_rd[N_SRC-1:0] = r_pend;
            w_sel_en:   w_rd[N_SRC-1:0] = r_en;
            w_sel_cur: begin
                w_rd[31]  = w_busy;
                w_rd[2:0] = r_id;
            end
            default: w_rd = '0;
        endcase
    end

    assign RD_HIT  = w_hit;
    assign RD_DATA = w_rd;
    assign INTR    = r_intr;

    // A new edge wins over a clear of the same bit in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pend  <= '0;
            r_en    <= '0;
            r_src_q <= '0;
            r_armed <= 1'b0;
        end else begin
            r_src_q <= SRC_IN;
            r_armed <= 1'b1;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (IOBUS_WR && w_sel_en) begin
                r_en <= IOBUS_OUT[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_cnt   <= '0;
            r_intr  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_id    <= w_next_id;
                        r_cnt   <= 4'(PULSE_CYC);
                        r_intr  <= 1'b1;
                        r_state <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= '0;
                        r_intr  <= 1'b0;
                        r_state <= ST_WAIT_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_ack_ok) begin
                        r_id    <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_intr  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed bench for intr_ctrl with a cycle-level
// reference model and hand-computed register/INTR expectations.
module tb_intr_ctrl;

    localparam int          N    = 4;
    localparam int          P    = 2;
    localparam logic [31:0] BASE = 32'h11000080;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  SRC_IN = '0;
    logic [31:0]   IOBUS_ADDR = BASE;
    logic [31:0]   IOBUS_OUT = '0;
    logic          IOBUS_WR = 1'b0;
    logic [31:0]   RD_DATA;
    logic          RD_HIT;
    logic          INTR;

    int n_vec = 0;
    int n_bad = 0;
    int rot   = 0;

    intr_ctrl #(
        .N_SRC(N),
        .BASE_AD(BASE),
        .PULSE_CYC(P)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .SRC_IN(SRC_IN),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR),
        .RD_DATA(RD_DATA),
        .RD_HIT(RD_HIT),
        .INTR(INTR)
    );

    always #10 CLK = ~CLK;

    // Reference model: pending set, enable set, and "serving id X with
    // m_left pulse cycles still to go" (m_left==0 while busy = awaiting ACK).
    logic [N-1:0] m_pend  = '0;
    logic [N-1:0] m_en    = '0;
    logic [N-1:0] m_prev  = '0;
    bit           m_armed = 1'b0;
    bit           m_busy  = 1'b0;
    int           m_left  = 0;
    int           m_id    = 0;

    always @(posedge CLK or posedge RST) begin
        logic [31:0]  off;
        logic [N-1:0] rise;
        logic [N-1:0] clr;
        logic [N-1:0] req;
        if (RST) begin
            m_pend  = '0;
            m_en    = '0;
            m_prev  = '0;
            m_armed = 1'b0;
            m_busy  = 1'b0;
            m_left  = 0;
            m_id    = 0;
        end else begin
            off  = IOBUS_ADDR - BASE;
            rise = m_armed ? (SRC_IN & ~m_prev) : '0;
            m_prev  = SRC_IN;
            m_armed = 1'b1;
            clr = (IOBUS_WR && off == 32'd0) ? IOBUS_OUT[N-1:0] : '0;
            req = m_pend & m_en;
            if (!m_busy) begin
                if (req != '0) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (req[i]) m_id = i;
                    m_busy = 1'b1;
                    m_left = P;
                end
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (IOBUS_WR && off == 32'd12
                         && IOBUS_OUT[2:0] == 3'(m_id)) begin
                clr[m_id] = 1'b1;
                m_busy = 1'b0;
                m_id   = 0;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (IOBUS_WR && off == 32'd4)
                m_en = IOBUS_OUT[N-1:0];
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        exp_rd = '0;
        if (o == 32'd0)      exp_rd = 32'(m_pend);
        else if (o == 32'd4) exp_rd = 32'(m_en);
        else if (o == 32'd8) exp_rd = {m_busy, 28'd0, 3'(m_id)};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("intr", 32'(INTR), 32'(m_busy && m_left > 0));
        check("hit", 32'(RD_HIT), 32'((IOBUS_ADDR - BASE) <= 32'd12));
        check("rd", RD_DATA, exp_rd(IOBUS_ADDR));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            IOBUS_WR   = 1'b0;
            IOBUS_OUT  = '0;
            IOBUS_ADDR = BASE + 32'(4 * (rot % 5));
            rot++;
        end
    endtask

    task automatic put(input int off, input logic [31:0] v);
        IOBUS_WR   = 1'b1;
        IOBUS_ADDR = BASE + 32'(off);
        IOBUS_OUT  = v;
    endtask

    task automatic rd(input int off, output logic [31:0] d);
        IOBUS_ADDR = BASE + 32'(off);
        #1;
        d = RD_DATA;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        // Sources held high through reset must not create requests.
        SRC_IN = 4'b0101;
        repeat (2) @(posedge CLK);
        #1;
        rd(0, d); check("rst_pend", d, 32'h0);
        rd(4, d); check("rst_en", d, 32'h0);
        rd(8, d); check("rst_cur", d, 32'h0);
        check("rst_intr", 32'(INTR), 32'h0);
        RST = 1'b0;
        cyc(3);
        rd(0, d); check("hold_pend", d, 32'h0);
        SRC_IN = '0;
        cyc(1);

        // Single source, 2-cycle pulse, ACK ignored during pulse.
        put(4, 32'h3); cyc(1);
        SRC_IN = 4'b0010; cyc(1);
        SRC_IN = '0;
        rd(0, d); check("t30_pend", d, 32'h2);
        check("t30_intr0", 32'(INTR), 32'h0);
        cyc(1);
        check("t30_intr1", 32'(INTR), 32'h1);
        rd(8, d); check("t30_cur", d, 32'h80000001);
        put(12, 32'h1); cyc(1);
        check("t30_intr2", 32'(INTR), 32'h1);
        rd(0, d); check("t30_pend2", d, 32'h2);
        cyc(1);
        check("t30_intr3", 32'(INTR), 32'h0);
        rd(8, d); check("t30_wait", d, 32'h80000001);
        put(12, 32'h1); cyc(1);
        rd(0, d); check("t30_ackp", d, 32'h0);
        rd(8, d); check("t30_ackc", d, 32'h0);
        cyc(2);

        // Simultaneous sources: lowest index first, then the other.
        put(4, 32'hF); cyc(1);
        SRC_IN = 4'b1001; cyc(1);
        SRC_IN = '0;
        cyc(1);
        rd(8, d); check("t31_id0", d, 32'h80000000);
        cyc(2);
        put(12, 32'h0); cyc(1);
        check("t31_gap", 32'(INTR), 32'h0);
        rd(0, d); check("t31_pend", d, 32'h8);
        cyc(1);
        check("t31_intr", 32'(INTR), 32'h1);
        rd(8, d); check("t31_id3", d, 32'h80000003);
        cyc(2);
        put(12, 32'h3); cyc(1);
        rd(0, d); check("t31_done", d, 32'h0);

        // Disabled source stays pending until enabled; clearing EN/PEND
        // mid-service does not abort.
        put(4, 32'h0); cyc(1);
        SRC_IN = 4'b0100; cyc(1);
        SRC_IN = '0;
        cyc(3);
        rd(0, d); check("t32_pend", d, 32'h4);
        check("t32_quiet", 32'(INTR), 32'h0);
        put(4, 32'h4); cyc(1);
        check("t32_lat", 32'(INTR), 32'h0);
        cyc(1);
        check("t32_intr", 32'(INTR), 32'h1);
        rd(8, d); check("t32_cur", d, 32'h80000002);
        cyc(2);
        put(4, 32'h0); cyc(1);
        put(0, 32'h4); cyc(1);
        rd(8, d); check("t32_stay", d, 32'h80000002);
        rd(0, d); check("t32_clr", d, 32'h0);
        put(12, 32'h2); cyc(1);
        rd(8, d); check("t32_ack", d, 32'h0);

        // Wrong-id ACK ignored; ACK racing a new edge re-dispatches.
        put(4, 32'h2); cyc(1);
        SRC_IN = 4'b0010; cyc(1);
        SRC_IN = '0;
        cyc(3);
        put(12, 32'h2); cyc(1);
        rd(8, d); check("t33_bad", d, 32'h80000001);
        rd(0, d); check("t33_pend", d, 32'h2);
        put(12, 32'h1);
        SRC_IN = 4'b0010; cyc(1);
        SRC_IN = '0;
        rd(0, d); check("t33_keep", d, 32'h2);
        check("t33_gap", 32'(INTR), 32'h0);
        cyc(1);
        check("t33_re", 32'(INTR), 32'h1);
        rd(8, d); check("t33_id", d, 32'h80000001);
        cyc(2);
        put(12, 32'h1); cyc(1);

        // W1C of all bits loses to a same-cycle edge; EN width masked.
        put(4, 32'h0); cyc(1);
        SRC_IN = 4'b1110; cyc(1);
        put(0, 32'hF);
        SRC_IN = 4'b1111; cyc(1);
        rd(0, d); check("t35_pend", d, 32'h1);
        put(0, 32'hF);
        SRC_IN = '0; cyc(1);
        rd(0, d); check("t35_clr", d, 32'h0);
        put(4, 32'hFF); cyc(1);
        rd(4, d); check("t17_en", d, 32'hF);
        put(4, 32'h0); cyc(1);

        // Reset during the second INTR cycle.
        put(4, 32'h1); cyc(1);
        SRC_IN = 4'b0001; cyc(1);
        SRC_IN = '0;
        cyc(2);
        check("t34_pre", 32'(INTR), 32'h1);
        RST = 1'b1;
        #1;
        check("t34_intr", 32'(INTR), 32'h0);
        rd(0, d); check("t34_pend", d, 32'h0);
        rd(4, d); check("t34_en", d, 32'h0);
        rd(8, d); check("t34_cur", d, 32'h0);
        SRC_IN = 4'b0001;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        put(4, 32'h1); cyc(4);
        check("t29_intr", 32'(INTR), 32'h0);
        rd(0, d); check("t29_pend", d, 32'h0);
        SRC_IN = '0; cyc(1);
        SRC_IN = 4'b0001; cyc(1);
        rd(0, d); check("t29_new", d, 32'h1);
        cyc(1);
        check("t29_fire", 32'(INTR), 32'h1);
        cyc(2);
        put(12, 32'h0); cyc(1);
        SRC_IN = '0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
